// File: rtl/fpu_f2i16_pkg.sv
// Shared types and constants for the FP16 -> int16 converter.
// Operand/status formats match the other FPU execute-stage units.
package fpu_f2i16_pkg;

   localparam int unsigned FP16_FRACW = 10;
   localparam int unsigned FP16_EXPW  = 5;
   localparam int unsigned FP16_BIAS  = 15;
   localparam int unsigned INT_W      = 16;
   localparam int unsigned ACC_W      = 32;
   localparam int unsigned ACC_FRACW  = 16;
   localparam int unsigned ACC_PAD    = ACC_FRACW - FP16_FRACW;
   localparam int unsigned CNT_W      = 4;

   // Exponent field values that select the dispatch path
   localparam logic [FP16_EXPW-1:0] EXP_HALF    = FP16_EXPW'(FP16_BIAS - 1);
   localparam logic [FP16_EXPW-1:0] EXP_ONE     = FP16_EXPW'(FP16_BIAS);
   localparam logic [FP16_EXPW-1:0] EXP_SAT     = FP16_EXPW'(FP16_BIAS + 15);
   localparam logic [FP16_EXPW-1:0] EXP_SPECIAL = FP16_EXPW'(31);

   localparam logic [INT_W-1:0] INT16_MAX = 16'h7FFF;
   localparam logic [INT_W-1:0] INT16_MIN = 16'h8000;

   typedef struct packed {
      logic                  sign;
      logic [FP16_EXPW-1:0]  exponent;
      logic [FP16_FRACW-1:0] frac;
   } fp16_t;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } condCode_t;

   typedef struct packed {
      logic invalid;
      logic div_zero;
      logic overflow;
      logic underflow;
      logic inexact;
   } opStatusFlag_t;

   typedef enum logic [1:0] {
      F2I_IDLE,
      F2I_SHIFT,
      F2I_ROUND,
      F2I_DONE
   } f2iState_t;

   function automatic condCode_t make_cc(input logic [INT_W-1:0] val, input logic invalid);
      condCode_t cc;
      cc.z = (val == '0);
      cc.c = 1'b0;
      cc.n = val[INT_W-1];
      cc.v = invalid;
      return cc;
   endfunction

endpackage

// File: rtl/fpu_f2i16_round.sv
// Round-to-nearest-even of a Q16.16 magnitude, sign application and
// int16 saturation.
module fpuRoundRNE
   import fpu_f2i16_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   input  logic             sticky,
   input  logic             sign,
   output logic [INT_W-1:0] result,
   output logic             inexact,
   output logic             overflow
);

   localparam logic [INT_W:0] POS_LIMIT = (INT_W+1)'(32767);
   localparam logic [INT_W:0] NEG_LIMIT = (INT_W+1)'(32768);

   logic [INT_W-1:0] int_part;
   logic             guard;
   logic             rest;
   logic             round_up;
   logic [INT_W:0]   mag;
   logic [INT_W-1:0] mag_lo;

   always_comb begin
      int_part = acc[ACC_W-1:ACC_FRACW];
      guard    = acc[ACC_FRACW-1];
      rest     = (|acc[ACC_FRACW-2:0]) | sticky;
      round_up = guard & (rest | acc[ACC_FRACW]);
      mag      = {1'b0, int_part} + (INT_W+1)'(round_up);
      mag_lo   = mag[INT_W-1:0];
      inexact  = guard | rest;
      // -32768 is representable, +32768 is not
      overflow = sign ? (mag > NEG_LIMIT) : (mag > POS_LIMIT);
      if (overflow) begin
         result = sign ? INT16_MIN : INT16_MAX;
      end else if (sign) begin
         result = ~mag_lo + INT_W'(1);
      end else begin
         result = mag_lo;
      end
   end

endmodule

// File: rtl/fpu_f2i16.sv
// FP16 -> signed int16 converter: denormalizes with a one-bit-per-cycle
// shifter, rounds RNE and saturates; valid/ready on both sides.
module fpu_f2i16
   import fpu_f2i16_pkg::*;
(
   input  logic             clock,
   input  logic             reset_L,
   input  logic             inValid,
   output logic             inReady,
   input  fp16_t            fpIn,
   output logic             outValid,
   input  logic             outReady,
   output logic [INT_W-1:0] intOut,
   output condCode_t        condCodes,
   output opStatusFlag_t    opStatusFlags
);

   f2iState_t        state_q,     state_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic             sticky_q,    sticky_d;
   logic             sign_q,      sign_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             left_q,      left_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [INT_W-1:0] int_out_q,   int_out_d;
   condCode_t        cc_q,        cc_d;
   opStatusFlag_t    flags_q,     flags_d;

   logic [INT_W-1:0] rnd_result;
   logic             rnd_inexact;
   logic             rnd_overflow;

   fpuRoundRNE u_round (
      .acc      (acc_q),
      .sticky   (sticky_q),
      .sign     (sign_q),
      .result   (rnd_result),
      .inexact  (rnd_inexact),
      .overflow (rnd_overflow)
   );

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sticky_d  = sticky_q;
      sign_d    = sign_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      int_out_d = int_out_q;
      flags_d   = flags_q;
      cc_d      = cc_q;

      case (state_q)
         F2I_IDLE: begin
            if (inValid) begin
               sign_d    = fpIn.sign;
               sticky_d  = 1'b0;
               // Hidden bit lands at weight 2^0 (bit 16) of the Q16.16 accumulator
               acc_d     = ACC_W'({1'b1, fpIn.frac, {ACC_PAD{1'b0}}});
               cnt_d     = '0;
               left_d    = 1'b1;
               int_out_d = '0;
               flags_d   = '0;
               if (fpIn.exponent == EXP_SPECIAL) begin
                  flags_d.invalid = 1'b1;
                  int_out_d       = (fpIn.sign && (fpIn.frac == '0)) ? INT16_MIN : INT16_MAX;
                  state_d         = F2I_DONE;
               end else if (fpIn.exponent < EXP_HALF) begin
                  flags_d.inexact = |fpIn.frac;
                  state_d         = F2I_DONE;
               end else if (fpIn.exponent >= EXP_SAT) begin
                  if (fpIn.sign && (fpIn.exponent == EXP_SAT) && (fpIn.frac == '0)) begin
                     int_out_d = INT16_MIN;
                  end else begin
                     int_out_d       = fpIn.sign ? INT16_MIN : INT16_MAX;
                     flags_d.invalid = 1'b1;
                  end
                  state_d = F2I_DONE;
               end else if (fpIn.exponent == EXP_HALF) begin
                  cnt_d   = CNT_W'(1);
                  left_d  = 1'b0;
                  state_d = F2I_SHIFT;
               end else begin
                  cnt_d   = CNT_W'(fpIn.exponent - EXP_ONE);
                  state_d = (fpIn.exponent == EXP_ONE) ? F2I_ROUND : F2I_SHIFT;
               end
            end
         end

         F2I_SHIFT: begin
            if (left_q) begin
               acc_d = {acc_q[ACC_W-2:0], 1'b0};
            end else begin
               acc_d    = {1'b0, acc_q[ACC_W-1:1]};
               sticky_d = sticky_q | acc_q[0];
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = F2I_ROUND;
            end
         end

         F2I_ROUND: begin
            int_out_d       = rnd_result;
            flags_d         = '0;
            flags_d.invalid = rnd_overflow;
            flags_d.inexact = rnd_inexact;
            state_d         = F2I_DONE;
         end

         F2I_DONE: begin
            if (outReady) begin
               state_d = F2I_IDLE;
            end
         end

         default: begin
            state_d = F2I_IDLE;
         end
      endcase

      in_ready_d  = (state_d == F2I_IDLE);
      out_valid_d = (state_d == F2I_DONE);
      // Condition codes are captured once, when the result is published
      if ((state_d == F2I_DONE) && (state_q != F2I_DONE)) begin
         cc_d = make_cc(int_out_d, flags_d.invalid);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         state_q     <= F2I_IDLE;
         acc_q       <= '0;
         sticky_q    <= 1'b0;
         sign_q      <= 1'b0;
         cnt_q       <= '0;
         left_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         int_out_q   <= '0;
         cc_q        <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         sign_q      <= sign_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         int_out_q   <= int_out_d;
         cc_q        <= cc_d;
         flags_q     <= flags_d;
      end
   end

   assign inReady       = in_ready_q;
   assign outValid      = out_valid_q;
   assign intOut        = int_out_q;
   assign condCodes     = cc_q;
   assign opStatusFlags = flags_q;

endmodule

// File: tb/tb_fpu_f2i16.sv
// Bench for fpu_f2i16: directed cases, randomized operands against an
// arithmetic reference model, backpressure and mid-operation reset.
module tb_fpu_f2i16;
   import fpu_f2i16_pkg::*;

   logic          clock = 1'b0;
   logic          reset_L;
   logic          inValid;
   logic          inReady;
   fp16_t         fpIn;
   logic          outValid;
   logic          outReady;
   logic [15:0]   intOut;
   condCode_t     condCodes;
   opStatusFlag_t opStatusFlags;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   fpu_f2i16 dut (
      .clock         (clock),
      .reset_L       (reset_L),
      .inValid       (inValid),
      .inReady       (inReady),
      .fpIn          (fpIn),
      .outValid      (outValid),
      .outReady      (outReady),
      .intOut        (intOut),
      .condCodes     (condCodes),
      .opStatusFlags (opStatusFlags)
   );

   // Flags as {invalid, div_zero, overflow, underflow, inexact}; cc as {Z,C,N,V}
   localparam logic [15:0] DIR_IN  [9] = '{16'h3E00, 16'h4100, 16'hBE00, 16'h3800, 16'hF800,
                                           16'h7BFF, 16'h7E00, 16'hFC00, 16'h6400};
   localparam logic [15:0] DIR_RES [9] = '{16'h0002, 16'h0002, 16'hFFFE, 16'h0000, 16'h8000,
                                           16'h7FFF, 16'h7FFF, 16'h8000, 16'h0400};
   localparam logic [4:0]  DIR_FLG [9] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000,
                                           5'b10000, 5'b10000, 5'b10000, 5'b00000};
   localparam logic [3:0]  DIR_CC  [9] = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0010,
                                           4'b0001, 4'b0001, 4'b0011, 4'b0000};
   localparam int          DIR_LAT [9] = '{2, 3, 2, 3, 1, 1, 1, 1, 12};

   // Reference: exact value m * 2^(E-10) rounded to nearest-even with integer division
   task automatic ref_model(input logic [15:0] x, output logic [15:0] res,
                            output logic [4:0] flg, output logic [3:0] cc, output int lat);
      int s, e, f, ee, m, sh, d, q, r, res_i;
      logic inv, inx;
      s = int'(x[15]);
      e = int'(x[14:10]);
      f = int'(x[9:0]);
      ee = e - 15;
      inv = 1'b0;
      inx = 1'b0;
      res_i = 0;
      lat = 1;
      if (e == 31) begin
         res_i = (s == 1 && f == 0) ? -32768 : 32767;
         inv = 1'b1;
      end else if (e == 0 || ee <= -2) begin
         res_i = 0;
         inx = (f != 0);
      end else if (ee >= 15) begin
         if (s == 1 && ee == 15 && f == 0) begin
            res_i = -32768;
         end else begin
            res_i = (s == 1) ? -32768 : 32767;
            inv = 1'b1;
         end
      end else begin
         m = 1024 + f;
         sh = ee - 10;
         if (sh >= 0) begin
            q = m << sh;
         end else begin
            d = 1 << (-sh);
            q = m / d;
            r = m % d;
            if ((2 * r > d) || ((2 * r == d) && (q % 2 == 1))) q = q + 1;
            inx = (r != 0);
         end
         if (s == 1) begin
            if (q > 32768) begin res_i = -32768; inv = 1'b1; end
            else res_i = -q;
         end else begin
            if (q > 32767) begin res_i = 32767; inv = 1'b1; end
            else res_i = q;
         end
         lat = (ee == -1) ? 3 : ee + 2;
      end
      res = res_i[15:0];
      flg = {inv, 3'b000, inx};
      cc  = {(res == 16'h0000), 1'b0, res[15], inv};
   endtask

   // Drives one operand, measures latency, captures the result and retires it
   task automatic run_op(input logic [15:0] x, output logic [15:0] res, output logic [3:0] cc,
                         output logic [4:0] flg, output int lat, output logic tmo);
      int n;
      n = 0;
      tmo = 1'b0;
      res = '0;
      cc = '0;
      flg = '0;
      lat = 0;
      fpIn = x;
      inValid = 1'b1;
      while (!inReady && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      if (!inReady) begin
         tmo = 1'b1;
         inValid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      inValid = 1'b0;
      fpIn = 16'($urandom);
      lat = 1;
      while (!outValid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      tmo = !outValid;
      res = intOut;
      cc = condCodes;
      flg = opStatusFlags;
      outReady = 1'b1;
      @(posedge clock); #1;
      outReady = 1'b0;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      inValid = 1'b0;
      outReady = 1'b0;
      fpIn = 16'h0000;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (intOut !== 16'h0000) begin failures++; $display("FAIL reset intOut got=%h exp=0000", intOut); end
      checks++; if (condCodes !== 4'h0) begin failures++; $display("FAIL reset condCodes got=%b exp=0000", condCodes); end
      checks++; if (opStatusFlags !== 5'h00) begin failures++; $display("FAIL reset flags got=%b exp=00000", opStatusFlags); end
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset outValid got=%b exp=0", outValid); end
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset inReady got=%b exp=1", inReady); end
      reset_L = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_directed();
      logic [15:0] res;
      logic [3:0]  cc;
      logic [4:0]  flg;
      int          lat;
      logic        tmo;
      for (int i = 0; i < 9; i++) begin
         run_op(DIR_IN[i], res, cc, flg, lat, tmo);
         checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL directed_timeout x=%h got=%b exp=0", DIR_IN[i], tmo); end
         checks++; if (res !== DIR_RES[i]) begin failures++; $display("FAIL directed_res x=%h got=%h exp=%h", DIR_IN[i], res, DIR_RES[i]); end
         checks++; if (flg !== DIR_FLG[i]) begin failures++; $display("FAIL directed_flags x=%h got=%b exp=%b", DIR_IN[i], flg, DIR_FLG[i]); end
         checks++; if (cc !== DIR_CC[i]) begin failures++; $display("FAIL directed_cc x=%h got=%b exp=%b", DIR_IN[i], cc, DIR_CC[i]); end
         checks++; if (lat != DIR_LAT[i]) begin failures++; $display("FAIL directed_latency x=%h got=%0d exp=%0d", DIR_IN[i], lat, DIR_LAT[i]); end
      end
   endtask

   task automatic test_random();
      logic [15:0] x, res, e_res;
      logic [3:0]  cc, e_cc;
      logic [4:0]  flg, e_flg;
      int          lat, e_lat;
      logic        tmo;
      for (int i = 0; i < 300; i++) begin
         x = 16'($urandom);
         if (i % 2 == 0) x[14:10] = 5'($urandom_range(13, 30));
         ref_model(x, e_res, e_flg, e_cc, e_lat);
         run_op(x, res, cc, flg, lat, tmo);
         checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL random_timeout x=%h got=%b exp=0", x, tmo); end
         checks++; if (res !== e_res) begin failures++; $display("FAIL random_res x=%h got=%h exp=%h", x, res, e_res); end
         checks++; if (flg !== e_flg) begin failures++; $display("FAIL random_flags x=%h got=%b exp=%b", x, flg, e_flg); end
         checks++; if (cc !== e_cc) begin failures++; $display("FAIL random_cc x=%h got=%b exp=%b", x, cc, e_cc); end
         checks++; if (lat != e_lat) begin failures++; $display("FAIL random_latency x=%h got=%0d exp=%0d", x, lat, e_lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] e_res;
      logic [3:0]  e_cc;
      logic [4:0]  e_flg;
      int          e_lat, n;
      ref_model(16'h4100, e_res, e_flg, e_cc, e_lat);
      fpIn = 16'h4100;
      inValid = 1'b1;
      n = 0;
      while (!inReady && n < 40) begin @(posedge clock); #1; n++; end
      @(posedge clock); #1;
      // A second operand offered while busy must be ignored
      fpIn = 16'h7E00;
      n = 1;
      while (!outValid && n < 40) begin @(posedge clock); #1; n++; end
      checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL bp_outvalid_timeout got=%b exp=1", outValid); end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (outValid !== 1'b1 || inReady !== 1'b0 || intOut !== e_res ||
             condCodes !== e_cc || opStatusFlags !== e_flg) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got v=%b r=%b res=%h cc=%b flg=%b exp v=1 r=0 res=%h cc=%b flg=%b",
                     c, outValid, inReady, intOut, condCodes, opStatusFlags, e_res, e_cc, e_flg);
         end
         @(posedge clock); #1;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      @(posedge clock); #1;
      outReady = 1'b0;
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL bp_release_outvalid got=%b exp=0", outValid); end
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL bp_release_inready got=%b exp=1", inReady); end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] res, e_res;
      logic [3:0]  cc, e_cc;
      logic [4:0]  flg, e_flg;
      int          lat, e_lat, n;
      logic        tmo, seen;
      fpIn = 16'h6400;
      inValid = 1'b1;
      n = 0;
      while (!inReady && n < 40) begin @(posedge clock); #1; n++; end
      @(posedge clock); #1;
      inValid = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL midreset_busy inReady got=%b exp=0", inReady); end
      reset_L = 1'b0;
      @(posedge clock); #1;
      checks++; if (intOut !== 16'h0000) begin failures++; $display("FAIL midreset_intOut got=%h exp=0000", intOut); end
      checks++; if (condCodes !== 4'h0) begin failures++; $display("FAIL midreset_cc got=%b exp=0000", condCodes); end
      checks++; if (opStatusFlags !== 5'h00) begin failures++; $display("FAIL midreset_flags got=%b exp=00000", opStatusFlags); end
      checks++; if (inReady !== 1'b1 || outValid !== 1'b0) begin failures++; $display("FAIL midreset_hs got r=%b v=%b exp r=1 v=0", inReady, outValid); end
      reset_L = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         if (outValid === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_stale_result got=%b exp=0", seen); end
      ref_model(16'h3E00, e_res, e_flg, e_cc, e_lat);
      run_op(16'h3E00, res, cc, flg, lat, tmo);
      checks++; if (tmo !== 1'b0 || res !== e_res || flg !== e_flg || cc !== e_cc || lat != e_lat) begin
         failures++;
         $display("FAIL midreset_next got tmo=%b res=%h flg=%b cc=%b lat=%0d exp tmo=0 res=%h flg=%b cc=%b lat=%0d",
                  tmo, res, flg, cc, lat, e_res, e_flg, e_cc, e_lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
